// File: rtl/cpu_control_unit.sv
// Fetch/decode/sequencing FSM for the 8-bit accumulator CPU: owns PC and IR,
// emits Moore-decoded memory strobes and accumulator load, one instruction at a time.
module cpu_control_unit #(
  parameter int PC_WIDTH   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RESET_PC   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     instMemDataBus,
  input  logic                      accZero,
  output logic [PC_WIDTH-1:0]       instMemAddrBus,
  output logic [DATA_WIDTH/2-1:0]   dataMemAddrBus,
  output logic [DATA_WIDTH/2-1:0]   opcode,
  output logic                      mReadFlag,
  output logic                      mWriteFlag,
  output logic                      accLoad,
  output logic                      halted
);

  localparam int OPW = DATA_WIDTH / 2;

  localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
  localparam logic [OPW-1:0] OP_STA = OPW'(4'h2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'h4);
  localparam logic [OPW-1:0] OP_AND = OPW'(4'h5);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'h6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(4'h7);
  localparam logic [OPW-1:0] OP_NOT = OPW'(4'h8);
  localparam logic [OPW-1:0] OP_JMP = OPW'(4'h9);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(4'hA);
  localparam logic [OPW-1:0] OP_LDI = OPW'(4'hB);
  localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, pc_nxt;
  logic [DATA_WIDTH-1:0] ir, ir_nxt;
  logic [OPW-1:0]        ir_op;
  logic [PC_WIDTH-1:0]   ir_target;

  assign ir_op          = ir[DATA_WIDTH-1:OPW];
  assign ir_target      = PC_WIDTH'(ir[OPW-1:0]);
  assign instMemAddrBus = pc;
  assign opcode         = ir_op;
  assign dataMemAddrBus = ir[OPW-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_FETCH;
      pc    <= PC_WIDTH'(RESET_PC);
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt  = S_FETCH;
    pc_nxt     = pc;
    ir_nxt     = ir;
    mReadFlag  = 1'b0;
    mWriteFlag = 1'b0;
    accLoad    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        ir_nxt    = instMemDataBus;
        pc_nxt    = pc + 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (ir_op)
          OP_HLT: state_nxt = S_HALT;
          OP_JMP: pc_nxt = ir_target;
          OP_JZ:  if (accZero) pc_nxt = ir_target;
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_nxt = S_READ;
          OP_STA: state_nxt = S_WRITE;
          OP_NOT, OP_LDI: state_nxt = S_EXEC;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_READ: begin
        mReadFlag = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        accLoad   = 1'b1;
        state_nxt = S_FETCH;
      end
      S_WRITE: begin
        mWriteFlag = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_HALT: begin
        halted    = 1'b1;
        state_nxt = S_HALT;
      end
      // Corrupted encodings fall back to a fresh fetch.
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed literal checks plus randomized programs
// compared every cycle against an instruction-level model.
module tb_cpu_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       accZero = 1'b0;
  logic [7:0] rom [16];
  logic [7:0] instMemDataBus;
  logic [3:0] instMemAddrBus;
  logic [3:0] dataMemAddrBus;
  logic [3:0] opcode;
  logic       mReadFlag, mWriteFlag, accLoad, halted;

  int checks = 0;
  int errors = 0;

  cpu_control_unit dut (
    .clock          (clock),
    .reset          (reset),
    .instMemDataBus (instMemDataBus),
    .accZero        (accZero),
    .instMemAddrBus (instMemAddrBus),
    .dataMemAddrBus (dataMemAddrBus),
    .opcode         (opcode),
    .mReadFlag      (mReadFlag),
    .mWriteFlag     (mWriteFlag),
    .accLoad        (accLoad),
    .halted         (halted)
  );

  always #5 clock = ~clock;

  assign instMemDataBus = rom[instMemAddrBus];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction-level model: each fetched instruction expands into the list of
  // {read, write, load} strobe values for its remaining cycles.
  logic [3:0] m_pc;
  logic [7:0] m_ir;
  bit         m_halt;
  bit         m_first;
  bit         mdl_valid = 0;
  logic [2:0] q[$];

  initial forever begin
    logic [7:0] ins;
    @(posedge clock);
    if (reset) begin
      m_pc = 4'd0; m_ir = 8'h00; m_halt = 0; q.delete(); mdl_valid = 1;
    end else if (mdl_valid && !m_halt) begin
      if (q.size() == 0) begin
        ins  = rom[m_pc];
        m_ir = ins;
        m_pc = m_pc + 4'd1;
        case (ins[7:4])
          4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: q = '{3'b000, 3'b100, 3'b001};
          4'h2:       q = '{3'b000, 3'b010};
          4'h8, 4'hB: q = '{3'b000, 3'b001};
          default:    q = '{3'b000};
        endcase
        m_first = 1;
      end else begin
        if (m_first) begin
          if (m_ir[7:4] == 4'h9) m_pc = m_ir[3:0];
          if (m_ir[7:4] == 4'hA && accZero) m_pc = m_ir[3:0];
          if (m_ir[7:4] == 4'hF) m_halt = 1;
          m_first = 0;
        end
        void'(q.pop_front());
      end
    end
  end

  initial forever begin
    logic [2:0] s;
    @(negedge clock);
    if (mdl_valid) begin
      s = (q.size() != 0) ? q[0] : 3'b000;
      chk("m_addr",   instMemAddrBus, m_pc);
      chk("m_opcode", opcode,         m_ir[7:4]);
      chk("m_dmaddr", dataMemAddrBus, m_ir[3:0]);
      chk("m_read",   mReadFlag,      s[2]);
      chk("m_write",  mWriteFlag,     s[1]);
      chk("m_load",   accLoad,        s[0]);
      chk("m_halted", halted,         m_halt);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  task automatic clr_rom();
    foreach (rom[i]) rom[i] = 8'h00;
  endtask

  // Leaves the bench observing cycle 1 (FETCH) right after release.
  task automatic do_reset();
    reset = 1'b1;
    adv(2);
    chk("rst_pc",     instMemAddrBus, 4'd0);
    chk("rst_read",   mReadFlag,  1'b0);
    chk("rst_write",  mWriteFlag, 1'b0);
    chk("rst_load",   accLoad,    1'b0);
    chk("rst_halted", halted,     1'b0);
    reset = 1'b0;
  endtask

  initial begin
    clr_rom();

    // LDA 10
    rom[0] = 8'h1A;
    do_reset();
    adv(1);
    chk("lda_opcode", opcode, 4'h1);
    chk("lda_dm_c2",  dataMemAddrBus, 4'hA);
    adv(1);
    chk("lda_read",   mReadFlag, 1'b1);
    chk("lda_dm_c3",  dataMemAddrBus, 4'hA);
    adv(1);
    chk("lda_load",   accLoad, 1'b1);
    chk("lda_pc",     instMemAddrBus, 4'd1);

    // STA 5
    clr_rom(); rom[0] = 8'h25;
    do_reset();
    adv(2);
    chk("sta_write",  mWriteFlag, 1'b1);
    chk("sta_dm",     dataMemAddrBus, 4'd5);
    chk("sta_read",   mReadFlag, 1'b0);
    chk("sta_load",   accLoad, 1'b0);
    adv(1);
    chk("sta_next",   instMemAddrBus, 4'd1);
    chk("sta_wr_off", mWriteFlag, 1'b0);

    // JMP 14, then wrap 15 -> 0
    clr_rom(); rom[0] = 8'h9E;
    do_reset();
    adv(2); chk("jmp_f14", instMemAddrBus, 4'd14);
    adv(2); chk("jmp_f15", instMemAddrBus, 4'd15);
    adv(2); chk("jmp_f0",  instMemAddrBus, 4'd0);

    // JZ 7 taken / not taken
    clr_rom(); rom[0] = 8'hA7;
    accZero = 1'b1;
    do_reset();
    adv(2); chk("jz_taken", instMemAddrBus, 4'd7);
    accZero = 1'b0;
    do_reset();
    adv(2); chk("jz_fall",  instMemAddrBus, 4'd1);

    // LDI 3 then HLT
    clr_rom(); rom[0] = 8'hB3; rom[1] = 8'hF0;
    do_reset();
    adv(2);
    chk("ldi_load", accLoad, 1'b1);
    chk("ldi_dm",   dataMemAddrBus, 4'd3);
    adv(3);
    chk("hlt_halted", halted, 1'b1);
    repeat (20) begin
      adv(1);
      chk("hlt_pc",   instMemAddrBus, 4'd2);
      chk("hlt_hold", halted, 1'b1);
    end
    reset = 1'b1;
    adv(1);
    chk("hlt_rst_halted", halted, 1'b0);
    chk("hlt_rst_pc",     instMemAddrBus, 4'd0);
    reset = 1'b0;

    // Reset in the middle of an ADD's READ cycle
    clr_rom(); rom[0] = 8'h31;
    do_reset();
    adv(2);
    chk("add_read", mReadFlag, 1'b1);
    reset = 1'b1;
    adv(1);
    chk("add_rst_read", mReadFlag, 1'b0);
    chk("add_rst_load", accLoad, 1'b0);
    chk("add_rst_pc",   instMemAddrBus, 4'd0);
    reset = 1'b0;
    adv(1);
    chk("add_no_load",  accLoad, 1'b0);

    // Randomized programs with occasional resets
    foreach (rom[i]) rom[i] = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      step();
      accZero = 1'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        foreach (rom[i]) rom[i] = 8'($urandom);
      end else begin
        reset = 1'b0;
      end
    end
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
